tlu_multi_ch_rx: RTL
====================

Name: tlu_multi_ch_rx

Overview:
N-channel successor to the single-channel TLU input receiver. It takes per-channel deserialized sample words, one word per CLK40 cycle, from upstream ddr deserializers. Per channel it performs edge extraction, multi-word ToT measurement with saturation, and digital-threshold qualification. A coincidence window, a veto mask and a trigger counter then combine the channels into one trigger pulse for the TLU master trigger logic.

Parameters:
N_CH, 4, number of input channels
SAMPLES, 16, samples per word per channel (power of 2, ≥4); PW = log2(SAMPLES)
TS_W, 4, coarse timestamp width; fine time width T_W = TS_W+PW
TOT_W, 8, ToT width in sample units; all-ones = saturated
WIN_W, 8, coincidence window counter width
CNT_W, 16, trigger counter width

Ports:
CLK40  in  1  sole clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
TDC_IN  in  N_CH*SAMPLES  channel c = bits [c*SAMPLES +: SAMPLES]; bit SAMPLES-1 is the earliest sample; position p = SAMPLES-1-bit
TIME_STAMP  in  TS_W  coarse time of the current word
EN  in  N_CH  per-channel enable
EN_INVERT  in  N_CH  per-channel polarity inversion, applied before edge detection
DIG_TH  in  TOT_W  hit qualifies when ToT > DIG_TH (shared by all channels)
WINDOW  in  WIN_W  cycles VALID stays high after a qualified hit
COINC_MASK  in  N_CH  channels required for coincidence
VETO_MASK  in  N_CH  channels whose VALID blocks a trigger
HIT  out  N_CH  one-cycle pulse per qualified hit
LAST_LE  out  N_CH*T_W  {TIME_STAMP,p} of the leading edge of the last completed pulse
LAST_TOT  out  N_CH*TOT_W  ToT of the last completed pulse (qualified or not)
VALID  out  N_CH  channel inside its coincidence window
TRIGGER  out  1  one-cycle coincidence pulse
TRG_CNT  out  CNT_W  number of TRIGGER pulses, wraps

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0; FSMs IDLE; per-channel prev-sample register = 1, so a line stuck high after reset never produces a rising edge.
- Edge definition: s[-1] = prev (bit 0 of the previous word, after inversion). Rising at p: s[p]=1, s[p-1]=0. Falling at p: s[p]=0, s[p-1]=1. prev updates every cycle, including cycles with EN=0.
- Channel FSM, evaluated once per word:
  - IDLE: on the earliest rising edge r, capture LE={TIME_STAMP,r}. If a falling edge f>r exists in the same word, complete with ToT=f-r. Otherwise go to HIGH and clear the cycle counter c.
  - HIGH: each word without a falling edge increments c (saturating). On the first falling edge f, complete with ToT = c*SAMPLES + SAMPLES + f - r, saturated to 2^TOT_W-1, then return to IDLE.
  - All edges in a word after a completion are ignored (dead time = rest of word).
- Completion: LAST_TOT and LAST_LE are registered with 1-cycle latency after the word. HIT=1 that cycle iff ToT > DIG_TH. A saturated ToT still qualifies if it exceeds DIG_TH.
- EN[c]=0: FSM forced to IDLE (a pulse in progress is aborted with no result), HIT[c]=0, VALID[c]=0, window counter cleared. LAST_* values are held.
- Window: a qualified HIT loads win_cnt=WINDOW; otherwise win_cnt decrements to 0. VALID = (win_cnt≠0), registered together with HIT. A new hit inside the window reloads the counter. WINDOW=0 gives VALID high for exactly the HIT cycle.
- Coincidence: coinc = |COINC_MASK & &(VALID|~COINC_MASK) & ~|(VALID&VETO_MASK). TRIGGER = coinc & ~coinc_d, registered 1 cycle after VALID. TRG_CNT increments on TRIGGER and wraps.
- A channel set in both COINC_MASK and VETO_MASK can never trigger; this is intended behaviour, not an error.
- COINC_MASK=0: no triggers.

Decomposition:
- Package tlu_rx_pkg: channel FSM state enum (IDLE, HIGH); functions first_rise(word,prev) and first_fall_after(word,prev,pos), which return {found,pos}; saturating add helper.
- Sub-module tlu_ch_edge: inversion, prev register, FSM, ToT, HIT, LAST_*, window counter. Instantiated N_CH times via generate.
- The top level holds coincidence, veto, TRIGGER and TRG_CNT.

Test Plan:
- ch0, word 16'h1F00 (rise p=3, fall p=8), DIG_TH=2, TIME_STAMP=5 → next cycle HIT[0]=1, LAST_TOT=5, LAST_LE=8'h53.
- ch0: rise p=3 in word k, all-ones word k+1, fall p=5 in word k+2 → LAST_TOT=34, one HIT.
- ch1 high for 20 words → LAST_TOT=255; with DIG_TH=255, HIT stays 0.
- COINC_MASK=4'b0011, WINDOW=3: ch0 hit at cycle 0, ch1 hit at cycle 2 → one TRIGGER, TRG_CNT=1. With the ch1 hit at cycle 5 instead → no TRIGGER.
- VETO_MASK=4'b0100, ch2 VALID overlapping a ch0/ch1 coincidence → TRIGGER=0. Repeat the coincidence once ch2's window has expired → TRIGGER=1.
- Reset with all inputs high, then release → no HIT. Drop EN[0] mid-pulse → no result, VALID[0]=0. Assert RST_N low mid-window → all outputs 0 immediately.

Source files
------------

// File: rtl/tlu_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tlu_rx_pkg
// Description : Shared types and helpers for the multi-channel TLU receiver.
//               Channel FSM state, first-edge search functions on a
//               deserialized sample word, and a saturating add.
// Revision    : 1.0 - initial release
// ============================================================================
package tlu_rx_pkg;

  // Channel state: waiting for a leading edge, or inside a multi-word pulse
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HIGH = 1'b1
  } ch_state_t;

  // Search helpers work on a word zero-extended to MAX_S bits; the live part
  // is the low n bits, with bit n-1 the earliest sample (position 0).
  localparam int MAX_S  = 64;
  localparam int MAX_PW = 6;

  // {found, position}
  typedef logic [MAX_PW:0] edge_t;

  // Earliest rising edge; prev stands in for the sample before position 0
  function automatic edge_t first_rise(input logic [MAX_S-1:0] word,
                                       input logic             prev,
                                       input int               n);
    edge_t             res;
    logic              cur;
    logic              prv;
    logic [MAX_PW-1:0] idx;
    res = '0;
    prv = prev;
    cur = 1'b0;
    idx = '0;
    for (int p = 0; p < MAX_S; p++) begin
      if (p < n) begin
        idx = MAX_PW'(n - 1 - p);
        cur = word[idx];
        if (!res[MAX_PW] && cur && !prv)
          res = {1'b1, MAX_PW'(p)};
        prv = cur;
      end
    end
    return res;
  endfunction

  // Earliest falling edge strictly after position pos (pos = -1: whole word)
  function automatic edge_t first_fall_after(input logic [MAX_S-1:0] word,
                                             input logic             prev,
                                             input int               n,
                                             input int               pos);
    edge_t             res;
    logic              cur;
    logic              prv;
    logic [MAX_PW-1:0] idx;
    res = '0;
    prv = prev;
    cur = 1'b0;
    idx = '0;
    for (int p = 0; p < MAX_S; p++) begin
      if (p < n) begin
        idx = MAX_PW'(n - 1 - p);
        cur = word[idx];
        if (!res[MAX_PW] && (p > pos) && !cur && prv)
          res = {1'b1, MAX_PW'(p)};
        prv = cur;
      end
    end
    return res;
  endfunction

  // a + b clipped to max_v
  function automatic int sat_add(input int a, input int b, input int max_v);
    int s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlu_ch_edge.sv
`default_nettype none
// ============================================================================
// Module      : tlu_ch_edge
// Description : One receiver channel. Polarity inversion, edge extraction
//               across word boundaries, multi-word ToT with saturation,
//               digital-threshold qualification and coincidence window.
// Revision    : 1.0 - initial release
// ============================================================================
module tlu_ch_edge
  import tlu_rx_pkg::*;
#(
  parameter int SAMPLES = 16,
  parameter int TS_W    = 4,
  parameter int TOT_W   = 8,
  parameter int WIN_W   = 8,
  localparam int PW     = $clog2(SAMPLES),
  localparam int T_W    = TS_W + PW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SAMPLES-1:0] word,
  input  logic [TS_W-1:0]    time_stamp,
  input  logic               en,
  input  logic               en_invert,
  input  logic [TOT_W-1:0]   dig_th,
  input  logic [WIN_W-1:0]   window,
  output logic               hit,
  output logic [T_W-1:0]     last_le,
  output logic [TOT_W-1:0]   last_tot,
  output logic               valid
);

  localparam int TOT_MAX = (1 << TOT_W) - 1;

  ch_state_t          state;
  ch_state_t          state_nx;
  logic [SAMPLES-1:0] s_word;
  logic [MAX_S-1:0]   s_ext;
  logic               prev;
  edge_t              rise;
  edge_t              fall;
  int                 fall_from;
  logic [TOT_W-1:0]   cyc;
  logic [TS_W-1:0]    le_ts;
  logic [PW-1:0]      le_pos;
  logic               start;
  logic               done;
  logic [TOT_W-1:0]   tot;
  logic [T_W-1:0]     le;
  logic               hit_nx;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIN_W-1:0]   win_nx;

  assign s_word = en_invert ? ~word : word;
  assign s_ext  = MAX_S'(s_word);

  // Edge search: in IDLE a fall only counts after the rise, in HIGH anywhere
  always_comb begin
    rise      = first_rise(s_ext, prev, SAMPLES);
    fall_from = (state == IDLE) ? int'(rise[MAX_PW-1:0]) : -1;
    fall      = first_fall_after(s_ext, prev, SAMPLES, fall_from);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; disabling the channel aborts any pulse in progress
  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise[MAX_PW] && !fall[MAX_PW]) state_nx = HIGH;
        HIGH:    if (fall[MAX_PW]) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Per-word outputs: pulse start, completion, ToT and leading-edge time
  always_comb begin
    start = 1'b0;
    done  = 1'b0;
    tot   = '0;
    le    = {le_ts, le_pos};
    if (en) begin
      case (state)
        IDLE: begin
          if (rise[MAX_PW]) begin
            le = {time_stamp, rise[PW-1:0]};
            if (fall[MAX_PW]) begin
              done = 1'b1;
              tot  = TOT_W'(sat_add(int'(fall[MAX_PW-1:0]),
                                    -int'(rise[MAX_PW-1:0]), TOT_MAX));
            end else begin
              start = 1'b1;
            end
          end
        end
        HIGH: begin
          if (fall[MAX_PW]) begin
            done = 1'b1;
            tot  = TOT_W'(sat_add(int'(cyc) * SAMPLES + SAMPLES + int'(fall[MAX_PW-1:0]),
                                  -int'(le_pos), TOT_MAX));
          end
        end
        default: ;
      endcase
    end
  end

  // Qualification and window reload/decay
  always_comb begin
    hit_nx = done && (tot > dig_th);
    if (!en)             win_nx = '0;
    else if (hit_nx)     win_nx = window;
    else if (win_cnt != '0) win_nx = win_cnt - 1'b1;
    else                 win_nx = '0;
  end

  // Datapath registers; prev starts high so a stuck-high line is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b1;
      cyc      <= '0;
      le_ts    <= '0;
      le_pos   <= '0;
      hit      <= 1'b0;
      last_le  <= '0;
      last_tot <= '0;
      win_cnt  <= '0;
      valid    <= 1'b0;
    end else begin
      prev <= s_word[0];
      if (start) begin
        cyc    <= '0;
        le_ts  <= time_stamp;
        le_pos <= rise[PW-1:0];
      end else if (en && (state == HIGH) && !done && (cyc != '1)) begin
        cyc <= cyc + 1'b1;
      end
      if (done) begin
        last_tot <= tot;
        last_le  <= le;
      end
      hit     <= hit_nx;
      win_cnt <= win_nx;
      valid   <= hit_nx | (win_nx != '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlu_multi_ch_rx.sv
`default_nettype none
// ============================================================================
// Module      : tlu_multi_ch_rx
// Description : N-channel TLU input receiver. Per-channel edge/ToT/threshold
//               processing, then coincidence with veto into a single trigger
//               pulse and a wrapping trigger counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tlu_multi_ch_rx
  import tlu_rx_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int SAMPLES = 16,
  parameter int TS_W    = 4,
  parameter int TOT_W   = 8,
  parameter int WIN_W   = 8,
  parameter int CNT_W   = 16,
  localparam int PW     = $clog2(SAMPLES),
  localparam int T_W    = TS_W + PW
) (
  input  logic                    CLK40,
  input  logic                    RST_N,
  input  logic [N_CH*SAMPLES-1:0] TDC_IN,
  input  logic [TS_W-1:0]         TIME_STAMP,
  input  logic [N_CH-1:0]         EN,
  input  logic [N_CH-1:0]         EN_INVERT,
  input  logic [TOT_W-1:0]        DIG_TH,
  input  logic [WIN_W-1:0]        WINDOW,
  input  logic [N_CH-1:0]         COINC_MASK,
  input  logic [N_CH-1:0]         VETO_MASK,
  output logic [N_CH-1:0]         HIT,
  output logic [N_CH*T_W-1:0]     LAST_LE,
  output logic [N_CH*TOT_W-1:0]   LAST_TOT,
  output logic [N_CH-1:0]         VALID,
  output logic                    TRIGGER,
  output logic [CNT_W-1:0]        TRG_CNT
);

  logic coinc;
  logic coinc_d;
  logic trg_nx;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tlu_ch_edge #(
      .SAMPLES (SAMPLES),
      .TS_W    (TS_W),
      .TOT_W   (TOT_W),
      .WIN_W   (WIN_W)
    ) u_ch (
      .clk        (CLK40),
      .rst_n      (RST_N),
      .word       (TDC_IN[c*SAMPLES +: SAMPLES]),
      .time_stamp (TIME_STAMP),
      .en         (EN[c]),
      .en_invert  (EN_INVERT[c]),
      .dig_th     (DIG_TH),
      .window     (WINDOW),
      .hit        (HIT[c]),
      .last_le    (LAST_LE[c*T_W +: T_W]),
      .last_tot   (LAST_TOT[c*TOT_W +: TOT_W]),
      .valid      (VALID[c])
    );
  end

  // All required channels inside their window and no veto channel active
  always_comb begin
    coinc  = (|COINC_MASK) & (&(VALID | ~COINC_MASK)) & ~(|(VALID & VETO_MASK));
    trg_nx = coinc & ~coinc_d;
  end

  // Rising edge of coincidence becomes the trigger pulse; count it
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      coinc_d <= 1'b0;
      TRIGGER <= 1'b0;
      TRG_CNT <= '0;
    end else begin
      coinc_d <= coinc;
      TRIGGER <= trg_nx;
      if (trg_nx) TRG_CNT <= TRG_CNT + 1'b1;
    end
  end

endmodule
`default_nettype wire
